// File: rtl/bus_pkg.sv
// Shared bus definitions for the slave_bus_if protocol.
//   ttype_t     : transfer type driven by the initiator (shared with slaves)
//   bmp_state_t : bus_master_port FSM states
//   BUS_WORD_W  : data/address word width
//   BUS_BE_W    : byte-enable width (one bit per byte lane)
package bus_pkg;

  localparam int unsigned BUS_WORD_W = 32;
  localparam int unsigned BUS_BE_W   = 4;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } ttype_t;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StWr,
    StRmwRd,
    StRmwWr,
    StResp
  } bmp_state_t;

  // States in which the port owns the bus and drives ss high.
  function automatic logic is_bus_state(bmp_state_t st);
    return (st == StRd) || (st == StWr) || (st == StRmwRd) || (st == StRmwWr);
  endfunction

endpackage

// File: rtl/bus_rmw_merge.sv
// Byte-lane merge for read-modify-write stores.
//   old_i    : word read back from the slave
//   new_i    : lane-aligned store data
//   be_i     : byte enables, bit i selects new_i byte i
//   merged_o : per byte, be_i[i] ? new_i byte : old_i byte
module bus_rmw_merge
  import bus_pkg::*;
(
  input  logic [BUS_WORD_W-1:0] old_i,
  input  logic [BUS_WORD_W-1:0] new_i,
  input  logic [BUS_BE_W-1:0]   be_i,
  output logic [BUS_WORD_W-1:0] merged_o
);

  always_comb begin
    merged_o = old_i;
    for (int i = 0; i < BUS_BE_W; i++) begin
      if (be_i[i]) begin
        merged_o[8*i +: 8] = new_i[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/bus_master_port.sv
// Initiator end of the slave_bus_if protocol. Converts core load/store requests into single
// outstanding bus transactions; sub-word stores become read-modify-write sequences because
// the bus has no byte strobes.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_*_i / req_ready_o : core request channel (accepted only in idle)
//   resp_valid_o        : one-cycle completion pulse, with resp_rdata_o / resp_err_o
//   bus_*               : addr, ss, ttype, wdata out; rdata, bdone in
// Optional feature: define BUS_TIMEOUT_EN to abort a transaction whose slave does not raise
// bdone within TIMEOUT_CYCLES cycles (resp_err_o=1, resp_rdata_o=0). Without it the port
// waits for bdone indefinitely and resp_err_o is tied low.
module bus_master_port
  import bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [BUS_WORD_W-1:0] req_addr_i,
  input  logic [BUS_WORD_W-1:0] req_wdata_i,
  input  logic [BUS_BE_W-1:0]   req_be_i,
  output logic                  resp_valid_o,
  output logic [BUS_WORD_W-1:0] resp_rdata_o,
  output logic                  resp_err_o,
  output logic [BUS_WORD_W-1:0] bus_addr_o,
  output logic                  bus_ss_o,
  output logic                  bus_ttype_o,
  output logic [BUS_WORD_W-1:0] bus_wdata_o,
  input  logic [BUS_WORD_W-1:0] bus_rdata_i,
  input  logic                  bus_bdone_i
);

  bmp_state_t state_q, state_d;

  logic [BUS_WORD_W-3:0] addr_q, addr_d;
  logic [BUS_WORD_W-1:0] wdata_q, wdata_d;
  logic [BUS_BE_W-1:0]   be_q, be_d;
  logic [BUS_WORD_W-1:0] rdata_q, rdata_d;
  logic [BUS_WORD_W-1:0] merged;
  logic                  timeout_hit;
  logic                  accept;

  // Byte offset is dropped: the bus only carries word addresses.
  logic [1:0] unused_addr_lsb;
  assign unused_addr_lsb = req_addr_i[1:0];

  assign accept = (state_q == StIdle) && req_valid_i;

  bus_rmw_merge u_merge (
    .old_i    (bus_rdata_i),
    .new_i    (wdata_q),
    .be_i     (be_q),
    .merged_o (merged)
  );

`ifdef BUS_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;

  assign timeout_hit = bus_ss_o && !bus_bdone_i && (cnt_q == 16'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    // Fresh budget for every bus phase, including RMW read -> write.
    if ((state_d != state_q) && is_bus_state(state_d)) begin
      cnt_d = '0;
    end else if (bus_ss_o && !bus_bdone_i) begin
      cnt_d = cnt_q + 16'd1;
    end
    if (accept) begin
      err_d = 1'b0;
    end else if (timeout_hit) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign resp_err_o = resp_valid_o && err_q;
`else
  logic [31:0] unused_timeout_cycles;
  assign unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_hit           = 1'b0;
  assign resp_err_o            = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          addr_d  = req_addr_i[BUS_WORD_W-1:2];
          wdata_d = req_wdata_i;
          be_d    = req_be_i;
          if (!req_we_i) begin
            state_d = StRd;
          end else if (req_be_i == 4'hF) begin
            state_d = StWr;
          end else if (req_be_i == 4'h0) begin
            state_d = StResp;
          end else begin
            state_d = StRmwRd;
          end
        end
      end
      StRd: begin
        if (bus_bdone_i) begin
          rdata_d = bus_rdata_i;
          state_d = StResp;
        end else if (timeout_hit) begin
          rdata_d = '0;
          state_d = StResp;
        end
      end
      StWr, StRmwWr: begin
        if (bus_bdone_i) begin
          state_d = StResp;
        end else if (timeout_hit) begin
          rdata_d = '0;
          state_d = StResp;
        end
      end
      StRmwRd: begin
        if (bus_bdone_i) begin
          wdata_d = merged;
          state_d = StRmwWr;
        end else if (timeout_hit) begin
          // Abort skips the write phase entirely.
          rdata_d = '0;
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
    end
  end

  assign req_ready_o  = (state_q == StIdle);
  assign resp_valid_o = (state_q == StResp);
  assign resp_rdata_o = rdata_q;
  assign bus_ss_o     = is_bus_state(state_q);
  assign bus_ttype_o  = ((state_q == StWr) || (state_q == StRmwWr)) ? WRITE : READ;
  assign bus_addr_o   = {addr_q, 2'b00};
  assign bus_wdata_o  = wdata_q;

endmodule

// File: tb/tb_bus_master_port.sv
// Scoreboard bench for bus_master_port: stimulus pushes expected bus beats and responses,
// separate monitors pop and compare. A small memory slave with programmable wait states
// answers the bus. Timeout scenario is built only with BUS_TIMEOUT_EN.
module tb_bus_master_port;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } resp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] bus_addr;
  logic        bus_ss;
  logic        bus_ttype;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_bdone;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  resp_t resp_q[$];
  beat_t bus_q[$];

  logic [31:0] mem [16];
  int          wait_cfg = 0;
  int          wcnt = 0;
  logic        stuck = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bus_master_port #(
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .req_be_i     (req_be),
    .resp_valid_o (resp_valid),
    .resp_rdata_o (resp_rdata),
    .resp_err_o   (resp_err),
    .bus_addr_o   (bus_addr),
    .bus_ss_o     (bus_ss),
    .bus_ttype_o  (bus_ttype),
    .bus_wdata_o  (bus_wdata),
    .bus_rdata_i  (bus_rdata),
    .bus_bdone_i  (bus_bdone)
  );

  // Memory slave: word index from addr[5:2], bdone after wait_cfg idle cycles.
  assign bus_rdata = mem[bus_addr[5:2]];
  assign bus_bdone = bus_ss && !stuck && (wcnt == wait_cfg);

  always @(posedge clk) begin
    if (!bus_ss || bus_bdone) wcnt <= 0;
    else wcnt <= wcnt + 1;
    if (bus_ss && bus_bdone && bus_ttype) mem[bus_addr[5:2]] <= bus_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bus monitor: every cycle with ss high must match the oldest pending beat.
  always @(negedge clk) begin
    if (rst_n && bus_ss) begin
      if (bus_q.size() == 0) begin
        chk("bus_unexpected_ss", {31'd0, bus_ss}, 32'd0);
      end else begin
        chk("bus_ttype", {31'd0, bus_ttype}, {31'd0, bus_q[0].we});
        chk("bus_addr", bus_addr, bus_q[0].addr);
        if (bus_q[0].we) chk("bus_wdata", bus_wdata, bus_q[0].wdata);
        chk("ready_busy", {31'd0, req_ready}, 32'd0);
        if (bus_bdone) void'(bus_q.pop_front());
      end
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      if (resp_q.size() == 0) begin
        chk("resp_unexpected", {31'd0, resp_valid}, 32'd0);
      end else begin
        resp_t e;
        e = resp_q.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
        chk("resp_cycle", cyc, e.cyc);
        chk("ready_resp", {31'd0, req_ready}, 32'd0);
      end
    end
  end

  task automatic push_beat(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    bus_q.push_back('{we, addr, wdata});
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input int lat, input logic [31:0] exp_rdata,
                       input logic exp_err, input logic exp_resp, output int acc);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("accept_timeout", {31'd0, req_ready}, 32'd1);
    acc = cyc;
    if (exp_resp) resp_q.push_back('{exp_rdata, exp_err, cyc + lat});
    @(posedge clk);
    #1;
    // Scramble the request lines: captured fields must not follow them.
    req_valid = 1'b0;
    req_we    = ~we;
    req_addr  = ~addr;
    req_wdata = ~wdata;
    req_be    = ~be;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (resp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (resp_q.size() != 0) begin
      chk("drain_timeout", resp_q.size(), 0);
      resp_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int a0, a1, n;
    for (int i = 0; i < 16; i++) mem[i] <= '0;
    mem[14] <= 32'h0000_0010;
    mem[1]  <= 32'h1122_3344;

    #12;
    chk("rst_ss", {31'd0, bus_ss}, 32'd0);
    chk("rst_ttype", {31'd0, bus_ttype}, 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", {31'd0, resp_err}, 32'd0);
    rst_n = 1'b1;

    // Load from clint mtime.
    push_beat(1'b0, 32'h0200_BFF8, 32'h0);
    issue(1'b0, 32'h0200_BFF8, 32'h0, 4'h0, 2, 32'h10, 1'b0, 1'b1, a0);
    wait_idle();

    // Full-word store to mtimecmp.
    push_beat(1'b1, 32'h0200_4000, 32'h100);
    issue(1'b1, 32'h0200_4000, 32'h100, 4'hF, 2, 32'h10, 1'b0, 1'b1, a0);
    wait_idle();
    chk("mem_mtimecmp", mem[0], 32'h100);

    // Sub-word store, byte offset bits ignored on the bus.
    push_beat(1'b0, 32'h8000_0004, 32'h0);
    push_beat(1'b1, 32'h8000_0004, 32'h1122_AB44);
    issue(1'b1, 32'h8000_0005, 32'h0000_AB00, 4'b0010, 3, 32'h10, 1'b0, 1'b1, a0);
    wait_idle();
    chk("mem_rmw1", mem[1], 32'h1122_AB44);

    // Store with no enabled bytes: response only, no bus activity.
    issue(1'b1, 32'h8000_0004, 32'hFFFF_FFFF, 4'h0, 1, 32'h10, 1'b0, 1'b1, a0);
    wait_idle();
    chk("mem_be0", mem[1], 32'h1122_AB44);

    // Slave with 5 wait cycles.
    wait_cfg = 5;
    push_beat(1'b0, 32'h8000_0004, 32'h0);
    issue(1'b0, 32'h8000_0004, 32'h0, 4'h0, 7, 32'h1122_AB44, 1'b0, 1'b1, a0);
    wait_idle();
    wait_cfg = 0;

    // Back-to-back loads: one acceptance every 3 cycles.
    push_beat(1'b0, 32'h0200_BFF8, 32'h0);
    issue(1'b0, 32'h0200_BFF8, 32'h0, 4'h0, 2, 32'h10, 1'b0, 1'b1, a0);
    push_beat(1'b0, 32'h8000_0004, 32'h0);
    issue(1'b0, 32'h8000_0004, 32'h0, 4'h0, 2, 32'h1122_AB44, 1'b0, 1'b1, a1);
    chk("b2b_gap", a1 - a0, 3);
    wait_idle();

    // RMW on outer byte lanes.
    push_beat(1'b0, 32'h0200_4000, 32'h0);
    push_beat(1'b1, 32'h0200_4000, 32'hDE00_01EF);
    issue(1'b1, 32'h0200_4000, 32'hDE00_00EF, 4'b1001, 3, 32'h1122_AB44, 1'b0, 1'b1, a0);
    wait_idle();
    chk("mem_rmw2", mem[0], 32'hDE00_01EF);

    // Reset while in the RMW write phase.
    wait_cfg = 3;
    push_beat(1'b0, 32'h8000_0004, 32'h0);
    push_beat(1'b1, 32'h8000_0004, 32'h1155_AB44);
    issue(1'b1, 32'h8000_0004, 32'h0055_0000, 4'b0100, 0, 32'h0, 1'b0, 1'b0, a0);
    n = 0;
    while (!(bus_ss && bus_ttype) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rmw_wr_reached", {31'd0, bus_ss && bus_ttype}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ss", {31'd0, bus_ss}, 32'd0);
    chk("rst_mid_resp", {31'd0, resp_valid}, 32'd0);
    chk("rst_mid_ready", {31'd0, req_ready}, 32'd1);
    bus_q.delete();
    wait_cfg = 0;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
    chk("post_rst_mem", mem[1], 32'h1122_AB44);
    push_beat(1'b0, 32'h8000_0004, 32'h0);
    issue(1'b0, 32'h8000_0004, 32'h0, 4'h0, 2, 32'h1122_AB44, 1'b0, 1'b1, a0);
    wait_idle();

`ifdef BUS_TIMEOUT_EN
    // Slave never answers: abort after 16 cycles of ss.
    stuck = 1'b1;
    push_beat(1'b0, 32'h0200_BFF8, 32'h0);
    issue(1'b0, 32'h0200_BFF8, 32'h0, 4'h0, 17, 32'h0, 1'b1, 1'b1, a0);
    wait_idle();
    chk("timeout_ss_low", {31'd0, bus_ss}, 32'd0);
    bus_q.delete();
    stuck = 1'b0;
`endif

    chk("bus_q_drained", bus_q.size(), 0);
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
